// File: rtl/rx_ts_os_decoder.sv
// ---------------------------------------------------------------------------
// rx_ts_os_decoder
//
// Per-lane receive decoder for TS1/TS2 training ordered sets. It takes 32-bit
// PIPE receive words (four symbols per pclk, with COM always in symbol 0),
// checks the 16-symbol set word by word, and reports the decoded fields. It
// also keeps a running count of consecutive identical sets for the LTSSM.
//
// Ports:
//   pclk            PIPE clock; every register updates on its rising edge
//   reset           synchronous, active-high reset
//   RxData[31:0]    received symbols, symbol 0 in [7:0], symbol 3 in [31:24]
//   RxDataK[3:0]    K flag per symbol, bit n belongs to symbol n
//   RxValid         receive word valid
//   RxStatus[2:0]   PIPE receive status for this lane
//   clear_count     LTSSM state-change pulse; clears the consecutive count
//   os_valid        one-cycle pulse per correctly decoded TS
//   os_type         0 = TS1, 1 = TS2
//   os_link_num     link number field (8'hF7 when PAD)
//   os_link_pad     link number field was the PAD K symbol
//   os_lane_num     lane number field (8'hF7 when PAD)
//   os_lane_pad     lane number field was the PAD K symbol
//   os_nfts         N_FTS field
//   os_rate_id      data rate identifier field
//   os_train_ctl    training control field
//   consec_count    consecutive identical TS count, saturating at 15
//   ts1_target_met  count reached CONSEC_TARGET and the last set was TS1
//   ts2_target_met  count reached CONSEC_TARGET and the last set was TS2
// ---------------------------------------------------------------------------
module rx_ts_os_decoder #(
    parameter int         CONSEC_TARGET = 8,
    parameter logic [7:0] TS1_ID        = 8'h4A,
    parameter logic [7:0] TS2_ID        = 8'h45
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [31:0] RxData,
    input  logic [3:0]  RxDataK,
    input  logic        RxValid,
    input  logic [2:0]  RxStatus,
    input  logic        clear_count,
    output logic        os_valid,
    output logic        os_type,
    output logic [7:0]  os_link_num,
    output logic        os_link_pad,
    output logic [7:0]  os_lane_num,
    output logic        os_lane_pad,
    output logic [7:0]  os_nfts,
    output logic [7:0]  os_rate_id,
    output logic [7:0]  os_train_ctl,
    output logic [3:0]  consec_count,
    output logic        ts1_target_met,
    output logic        ts2_target_met
);

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam logic [7:0] PAD_SYM = 8'hF7;
    localparam logic [3:0] TARGET  = 4'(CONSEC_TARGET);

    typedef enum logic [1:0] {
        HUNT,
        S1,
        S2,
        S3
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Per-symbol views of the incoming word.
    logic [7:0] w_sym0;
    logic [7:0] w_sym1;
    logic [7:0] w_sym2;
    logic [7:0] w_sym3;

    logic       w_good;
    logic       w_com0;
    logic       w_linkOk;
    logic       w_laneOk;
    logic       w_w0Ok;
    logic       w_idKnown;
    logic       w_w1Ok;
    logic       w_idOk;

    logic       w_latchW0;
    logic       w_latchW1;
    logic       w_complete;
    logic       w_abort;

    logic       w_match;
    logic [3:0] w_incCount;
    logic [3:0] w_newCount;

    // Fields of the set currently being assembled.
    logic [7:0] r_curLink;
    logic       r_curLinkPad;
    logic [7:0] r_curLane;
    logic       r_curLanePad;
    logic [7:0] r_curNfts;
    logic [7:0] r_curRate;
    logic [7:0] r_curTrain;
    logic [7:0] r_curId;
    logic       r_curType;

    // Registered outputs. The last completed set's fields double as the
    // "previous TS" record; r_prevValid says whether that record may be used.
    logic       r_osValid;
    logic       r_osType;
    logic [7:0] r_osLink;
    logic       r_osLinkPad;
    logic [7:0] r_osLane;
    logic       r_osLanePad;
    logic [7:0] r_osNfts;
    logic [7:0] r_osRate;
    logic [7:0] r_osTrain;
    logic [3:0] r_count;
    logic       r_prevValid;
    logic       r_ts1Met;
    logic       r_ts2Met;

    assign w_sym0 = RxData[7:0];
    assign w_sym1 = RxData[15:8];
    assign w_sym2 = RxData[23:16];
    assign w_sym3 = RxData[31:24];

    // A word is usable only when valid and free of decode, underflow and
    // disparity errors.
    assign w_good = RxValid &&
                    (RxStatus != 3'b100) &&
                    (RxStatus != 3'b110) &&
                    (RxStatus != 3'b111);

    assign w_com0 = RxDataK[0] && (w_sym0 == COM_SYM);

    // Link and lane may only be a K symbol when that symbol is PAD.
    assign w_linkOk = !RxDataK[1] || (w_sym1 == PAD_SYM);
    assign w_laneOk = !RxDataK[2] || (w_sym2 == PAD_SYM);
    assign w_w0Ok   = w_com0 && w_linkOk && w_laneOk && !RxDataK[3];

    // Symbol 6 picks the set type; symbol 7 must repeat it.
    assign w_idKnown = (w_sym2 == TS1_ID) || (w_sym2 == TS2_ID);
    assign w_w1Ok    = (RxDataK == 4'b0000) && w_idKnown && (w_sym3 == w_sym2);

    // W2 and W3 are four copies of the identifier latched from W1.
    assign w_idOk = (RxDataK == 4'b0000) &&
                    (w_sym0 == r_curId) && (w_sym1 == r_curId) &&
                    (w_sym2 == r_curId) && (w_sym3 == r_curId);

    // Comparison of the completing set against the previous record; N_FTS,
    // rate and training control are deliberately left out.
    assign w_match = r_prevValid &&
                     (r_curType    == r_osType)    &&
                     (r_curLink    == r_osLink)    &&
                     (r_curLinkPad == r_osLinkPad) &&
                     (r_curLane    == r_osLane)    &&
                     (r_curLanePad == r_osLanePad);

    assign w_incCount = (r_count == 4'd15) ? 4'd15 : (r_count + 4'd1);
    assign w_newCount = w_match ? w_incCount : 4'd1;

    // State register for the word-by-word ordered-set tracker.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Besides choosing the next state this raises the
    // strobes that tell the datapath to latch W0/W1 fields, to finish a set,
    // or to drop the partial set. A COM in symbol 0 while mid-set aborts the
    // old set but is also taken as the W0 of a new one.
    always_comb begin
        w_nextState = r_state;
        w_latchW0   = 1'b0;
        w_latchW1   = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;

        case (r_state)
            HUNT: begin
                if (w_good && w_w0Ok) begin
                    w_nextState = S1;
                    w_latchW0   = 1'b1;
                end
            end

            S1, S2, S3: begin
                if (!w_good) begin
                    w_nextState = HUNT;
                    w_abort     = 1'b1;
                end else if (w_com0) begin
                    w_abort = 1'b1;
                    if (w_w0Ok) begin
                        w_nextState = S1;
                        w_latchW0   = 1'b1;
                    end else begin
                        w_nextState = HUNT;
                    end
                end else if (r_state == S1) begin
                    if (w_w1Ok) begin
                        w_nextState = S2;
                        w_latchW1   = 1'b1;
                    end else begin
                        w_nextState = HUNT;
                        w_abort     = 1'b1;
                    end
                end else if (w_idOk) begin
                    if (r_state == S2) begin
                        w_nextState = S3;
                    end else begin
                        w_nextState = HUNT;
                        w_complete  = 1'b1;
                    end
                end else begin
                    w_nextState = HUNT;
                    w_abort     = 1'b1;
                end
            end

            default: begin
                w_nextState = HUNT;
            end
        endcase
    end

    // Capture the fields of the set in flight as its W0 and W1 arrive.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_curLink    <= 8'h00;
            r_curLinkPad <= 1'b0;
            r_curLane    <= 8'h00;
            r_curLanePad <= 1'b0;
            r_curNfts    <= 8'h00;
            r_curRate    <= 8'h00;
            r_curTrain   <= 8'h00;
            r_curId      <= 8'h00;
            r_curType    <= 1'b0;
        end else begin
            if (w_latchW0) begin
                r_curLink    <= w_sym1;
                r_curLinkPad <= RxDataK[1];
                r_curLane    <= w_sym2;
                r_curLanePad <= RxDataK[2];
                r_curNfts    <= w_sym3;
            end
            if (w_latchW1) begin
                r_curRate  <= w_sym0;
                r_curTrain <= w_sym1;
                r_curId    <= w_sym2;
                r_curType  <= (w_sym2 == TS2_ID);
            end
        end
    end

    // Output fields, completion pulse and consecutive counter. clear_count
    // wins over a same-cycle completion: the pulse and fields still go out,
    // but the count stays at zero and the record stays invalid.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_osValid   <= 1'b0;
            r_osType    <= 1'b0;
            r_osLink    <= 8'h00;
            r_osLinkPad <= 1'b0;
            r_osLane    <= 8'h00;
            r_osLanePad <= 1'b0;
            r_osNfts    <= 8'h00;
            r_osRate    <= 8'h00;
            r_osTrain   <= 8'h00;
            r_count     <= 4'd0;
            r_prevValid <= 1'b0;
            r_ts1Met    <= 1'b0;
            r_ts2Met    <= 1'b0;
        end else begin
            r_osValid <= w_complete;

            if (w_complete) begin
                r_osType    <= r_curType;
                r_osLink    <= r_curLink;
                r_osLinkPad <= r_curLinkPad;
                r_osLane    <= r_curLane;
                r_osLanePad <= r_curLanePad;
                r_osNfts    <= r_curNfts;
                r_osRate    <= r_curRate;
                r_osTrain   <= r_curTrain;
            end

            if (clear_count || w_abort) begin
                r_count     <= 4'd0;
                r_prevValid <= 1'b0;
                r_ts1Met    <= 1'b0;
                r_ts2Met    <= 1'b0;
            end else if (w_complete) begin
                r_count     <= w_newCount;
                r_prevValid <= 1'b1;
                r_ts1Met    <= (w_newCount >= TARGET) && !r_curType;
                r_ts2Met    <= (w_newCount >= TARGET) &&  r_curType;
            end
        end
    end

    assign os_valid       = r_osValid;
    assign os_type        = r_osType;
    assign os_link_num    = r_osLink;
    assign os_link_pad    = r_osLinkPad;
    assign os_lane_num    = r_osLane;
    assign os_lane_pad    = r_osLanePad;
    assign os_nfts        = r_osNfts;
    assign os_rate_id     = r_osRate;
    assign os_train_ctl   = r_osTrain;
    assign consec_count   = r_count;
    assign ts1_target_met = r_ts1Met;
    assign ts2_target_met = r_ts2Met;

endmodule
